// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon memory game: FSM states, PS/2 key codes,
// screen colour codes, tone half-periods and small display helpers.
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_WAIT_IN,
    S_PRESS,
    S_FAIL
  } state_t;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_C0    = 8'h1C;
  localparam logic [7:0] KEY_C1    = 8'h1B;
  localparam logic [7:0] KEY_C2    = 8'h23;
  localparam logic [7:0] KEY_C3    = 8'h2B;

  localparam logic [2:0] BG_DARK = 3'd0;
  localparam logic [2:0] BG_FAIL = 3'd5;

  localparam logic [19:0] TONE_C0   = 20'd95556;
  localparam logic [19:0] TONE_C1   = 20'd75843;
  localparam logic [19:0] TONE_C2   = 20'd63776;
  localparam logic [19:0] TONE_C3   = 20'd47778;
  localparam logic [19:0] TONE_FAIL = 20'd227272;

  localparam logic [4:0] DIGIT_BLANK = 5'b10000;

  // Everything the screen and tone generator see, registered as one word
  typedef struct packed {
    logic [2:0]  bg;
    logic        audio_res;
    logic [19:0] half_wav;
  } av_t;

  localparam av_t AV_DARK = '{bg: BG_DARK, audio_res: 1'b1, half_wav: 20'd0};
  localparam av_t AV_FAIL = '{bg: BG_FAIL, audio_res: 1'b0, half_wav: TONE_FAIL};

  function automatic logic [19:0] tone_of(input logic [1:0] c);
    logic [19:0] t;
    case (c)
      2'd0:    t = TONE_C0;
      2'd1:    t = TONE_C1;
      2'd2:    t = TONE_C2;
      default: t = TONE_C3;
    endcase
    return t;
  endfunction

  function automatic av_t lit(input logic [1:0] c);
    av_t a;
    a.bg        = {1'b0, c} + 3'd1;
    a.audio_res = 1'b0;
    a.half_wav  = tone_of(c);
    return a;
  endfunction

  // Returns {tens, units}; a zero tens digit is shown blank
  function automatic logic [9:0] to_bcd(input logic [6:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(v / 7'd10);
    units = 4'(v % 7'd10);
    return {(tens == 4'd0) ? DIGIT_BLANK : {1'b0, tens}, {1'b0, units}};
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4, shifting left) supplying the next colour
// from its two low bits; it only moves when the game appends a step.
module simon_lfsr #(
  parameter logic [7:0] SEED = 8'hB5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  output logic [1:0] colour
);

  logic [7:0] q;

  always_ff @(posedge clk) begin
    if (reset)
      q <= SEED;
    else if (advance)
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

  assign colour = q[1:0];

endmodule

// File: rtl/processor.sv
// Simon game controller: plays back a growing colour sequence and checks the player's
// PS/2 key presses. Define SIMON_MAX_SCORE_EN to keep and display the best score.
module processor
  import simon_pkg::*;
#(
  parameter int STEP_CYCLES  = 16,
  parameter int GAP_CYCLES   = 4,
  parameter int PRESS_CYCLES = 8,
  parameter int FAIL_CYCLES  = 32,
  parameter int MAX_LEN      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  keycode,
  input  logic        keycode_ready,
  input  logic        make,
  output logic [4:0]  level_01,
  output logic [4:0]  level_10,
  output logic [4:0]  max_score_01,
  output logic [4:0]  max_score_10,
  output logic [2:0]  bg,
  output logic        audio_res,
  output logic [19:0] half_wav
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t      state;
  logic [6:0]  length;
  logic [6:0]  index;
  logic [15:0] count;
  av_t         av;
  logic [1:0]  seq [MAX_LEN];
  logic [1:0]  lfsr_colour;
  logic [1:0]  first_colour;
  logic [6:0]  next_index;
  logic        key_event;
  logic        key_enter;
  logic        key_hit;
  logic [1:0]  key_col;

  simon_lfsr #(.SEED(8'hB5)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .advance(state == S_GEN),
    .colour (lfsr_colour)
  );

  always_comb begin
    key_event = keycode_ready && make;
    key_enter = key_event && (keycode == KEY_ENTER);
    key_hit   = 1'b0;
    key_col   = 2'd0;
    if (key_event) begin
      case (keycode)
        KEY_C0:  begin key_hit = 1'b1; key_col = 2'd0; end
        KEY_C1:  begin key_hit = 1'b1; key_col = 2'd1; end
        KEY_C2:  begin key_hit = 1'b1; key_col = 2'd2; end
        KEY_C3:  begin key_hit = 1'b1; key_col = 2'd3; end
        default: ;
      endcase
    end
  end

  assign next_index   = index + 7'd1;
  // On the first level seq[0] is being written in this very cycle
  assign first_colour = (length == 7'd0) ? lfsr_colour : seq[0];

  always_ff @(posedge clk) begin
    if (state == S_GEN)
      seq[length[IW-1:0]] <= lfsr_colour;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      length <= 7'd0;
      index  <= 7'd0;
      count  <= 16'd0;
      av     <= AV_DARK;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_enter) begin
            length <= 7'd0;
            index  <= 7'd0;
            state  <= S_GEN;
          end
        end
        S_GEN: begin
          length <= length + 7'd1;
          index  <= 7'd0;
          count  <= 16'd0;
          av     <= lit(first_colour);
          state  <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (count == 16'(STEP_CYCLES - 1)) begin
            count <= 16'd0;
            av    <= AV_DARK;
            state <= S_SHOW_OFF;
          end else begin
            count <= count + 16'd1;
          end
        end
        S_SHOW_OFF: begin
          if (count == 16'(GAP_CYCLES - 1)) begin
            count <= 16'd0;
            if (next_index == length) begin
              index <= 7'd0;
              state <= S_WAIT_IN;
            end else begin
              index <= next_index;
              av    <= lit(seq[next_index[IW-1:0]]);
              state <= S_SHOW_ON;
            end
          end else begin
            count <= count + 16'd1;
          end
        end
        S_WAIT_IN: begin
          if (key_hit) begin
            count <= 16'd0;
            if (key_col == seq[index[IW-1:0]]) begin
              av    <= lit(key_col);
              state <= S_PRESS;
            end else begin
              av    <= AV_FAIL;
              state <= S_FAIL;
            end
          end
        end
        S_PRESS: begin
          if (count == 16'(PRESS_CYCLES - 1)) begin
            count <= 16'd0;
            av    <= AV_DARK;
            if (next_index == length) begin
              index <= 7'd0;
              if (length == 7'(MAX_LEN)) begin
                length <= 7'd0;
                state  <= S_IDLE;
              end else begin
                state <= S_GEN;
              end
            end else begin
              index <= next_index;
              state <= S_WAIT_IN;
            end
          end else begin
            count <= count + 16'd1;
          end
        end
        S_FAIL: begin
          if (count == 16'(FAIL_CYCLES - 1)) begin
            count  <= 16'd0;
            av     <= AV_DARK;
            length <= 7'd0;
            index  <= 7'd0;
            state  <= S_IDLE;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bg        = av.bg;
  assign audio_res = av.audio_res;
  assign half_wav  = av.half_wav;
  assign {level_10, level_01} = to_bcd(length);

`ifdef SIMON_MAX_SCORE_EN
  logic [6:0] best;
  logic       fail_done;
  logic       win_done;

  assign fail_done = (state == S_FAIL) && (count == 16'(FAIL_CYCLES - 1));
  assign win_done  = (state == S_PRESS) && (count == 16'(PRESS_CYCLES - 1)) &&
                     (next_index == length) && (length == 7'(MAX_LEN));

  // Score on a miss is the last level fully completed
  always_ff @(posedge clk) begin
    if (reset)
      best <= 7'd0;
    else if (win_done)
      best <= 7'(MAX_LEN);
    else if (fail_done && (length - 7'd1 > best))
      best <= length - 7'd1;
  end

  assign {max_score_10, max_score_01} = to_bcd(best);
`else
  assign max_score_10 = DIGIT_BLANK;
  assign max_score_01 = DIGIT_BLANK;
`endif

endmodule

// File: tb/tb_processor.sv
// Randomized bench for the Simon controller: a game-level model predicts every lit
// screen segment (colour, tone, duration) and a negedge monitor scores the DUT against it.
module tb_processor;

  localparam int STEP  = 16;
  localparam int GAP   = 4;
  localparam int PRESS = 8;
  localparam int FAILC = 32;
  localparam int MAXL  = 32;

  localparam int NZ_BUSY = 0;
  localparam int NZ_WAIT = 1;
  localparam int NZ_IDLE = 2;

  localparam logic [23:0] DARK = {3'd0, 1'b1, 20'd0};

  typedef struct {
    logic [2:0]  bg;
    logic        ar;
    logic [19:0] hw;
    int          len;
  } seg_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  keycode;
  logic        keycode_ready;
  logic        make;
  logic [4:0]  level_01, level_10, max_score_01, max_score_10;
  logic [2:0]  bg;
  logic        audio_res;
  logic [19:0] half_wav;

  int          total = 0;
  int          bad = 0;
  seg_t        exp_q[$];
  bit          mon_on = 1'b0;
  logic [7:0]  m_lfsr;
  int          m_seq[$];
  int          m_best;
  int          tone_tab [4] = '{95556, 75843, 63776, 47778};
  logic [7:0]  key_tab [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};

  processor #(
    .STEP_CYCLES (STEP),
    .GAP_CYCLES  (GAP),
    .PRESS_CYCLES(PRESS),
    .FAIL_CYCLES (FAILC),
    .MAX_LEN     (MAXL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .keycode      (keycode),
    .keycode_ready(keycode_ready),
    .make         (make),
    .level_01     (level_01),
    .level_10     (level_10),
    .max_score_01 (max_score_01),
    .max_score_10 (max_score_10),
    .bg           (bg),
    .audio_res    (audio_res),
    .half_wav     (half_wav)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [9:0] bcd(input int v);
    logic [4:0] t;
    logic [4:0] u;
    u = 5'(v % 10);
    t = (v / 10 == 0) ? 5'b10000 : 5'(v / 10);
    return {t, u};
  endfunction

  function automatic logic [9:0] exp_max();
`ifdef SIMON_MAX_SCORE_EN
    return bcd(m_best);
`else
    return {5'b10000, 5'b10000};
`endif
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic bit is_mapped(input logic [7:0] c);
    return c == 8'h5A || c == 8'h1C || c == 8'h1B || c == 8'h23 || c == 8'h2B;
  endfunction

  task automatic push_seg(input int b, input int len, input int tone);
    seg_t s;
    s.bg  = 3'(b);
    s.ar  = 1'b0;
    s.hw  = 20'(tone);
    s.len = len;
    exp_q.push_back(s);
  endtask

  task automatic drive_cycle(input logic [7:0] code, input logic mk, input logic rdy);
    keycode       = code;
    make          = mk;
    keycode_ready = rdy;
    @(posedge clk);
    #1;
    keycode_ready = 1'b0;
    make          = 1'b0;
  endtask

  // Cycles that may carry key traffic the DUT must ignore in its current state
  task automatic noise_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      logic [7:0] code;
      logic       mk;
      logic       rdy;
      rdy = ($urandom_range(3) == 0);
      case ($urandom_range(2))
        0:       code = key_tab[$urandom_range(3)];
        1:       code = 8'h5A;
        default: code = 8'($urandom_range(255));
      endcase
      mk = 1'($urandom_range(1));
      if (rdy && mode == NZ_WAIT && is_mapped(code) && code != 8'h5A) mk = 1'b0;
      if (rdy && mode == NZ_IDLE && code == 8'h5A) mk = 1'b0;
      drive_cycle(code, mk, rdy);
    end
  endtask

  task automatic check_idle(input string p);
    check({p, "_bg"}, 32'(bg), 0);
    check({p, "_audio_res"}, 32'(audio_res), 1);
    check({p, "_half_wav"}, 32'(half_wav), 0);
    check({p, "_level"}, 32'({level_10, level_01}), 32'(bcd(0)));
    check({p, "_max"}, 32'({max_score_10, max_score_01}), 32'(exp_max()));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("queue_drain", exp_q.size(), 0);
  endtask

  // fail_level 0 plays a perfect game up to MAXL
  task automatic play_game(input int fail_level);
    int len;
    int fail_idx;
    noise_cycles($urandom_range(3), NZ_IDLE);
    drive_cycle(8'h5A, 1'b1, 1'b1);
    m_seq.delete();
    while (1) begin
      m_seq.push_back(int'(m_lfsr[1:0]));
      m_lfsr = lfsr_next(m_lfsr);
      len = m_seq.size();
      foreach (m_seq[j]) push_seg(m_seq[j] + 1, STEP, tone_tab[m_seq[j]]);
      noise_cycles(1 + len * (STEP + GAP), NZ_BUSY);
      check("level", 32'({level_10, level_01}), 32'(bcd(len)));
      fail_idx = (len == fail_level) ? int'($urandom_range(len - 1)) : -1;
      for (int i = 0; i < len; i++) begin
        noise_cycles($urandom_range(3), NZ_WAIT);
        if (i == fail_idx) begin
          int wrong;
          wrong = (m_seq[i] + 1 + int'($urandom_range(2))) % 4;
          push_seg(5, FAILC, 227272);
          drive_cycle(key_tab[wrong], 1'b1, 1'b1);
          noise_cycles(FAILC, NZ_BUSY);
          if (len - 1 > m_best) m_best = len - 1;
          check_idle("after_fail");
          return;
        end
        push_seg(m_seq[i] + 1, PRESS, tone_tab[m_seq[i]]);
        drive_cycle(key_tab[m_seq[i]], 1'b1, 1'b1);
        noise_cycles(PRESS, NZ_BUSY);
      end
      if (len == MAXL) begin
        m_best = MAXL;
        check_idle("after_win");
        return;
      end
    end
  endtask

  // Scores each lit segment once it ends: colour, tone, silence flag and length
  logic [23:0] prev_av = DARK;
  int          run_len = 0;

  always @(negedge clk) begin : monitor
    logic [23:0] cur;
    seg_t        e;
    cur = {bg, audio_res, half_wav};
    if (!mon_on) begin
      prev_av = DARK;
      run_len = 0;
    end else if (cur === prev_av) begin
      run_len++;
    end else begin
      if (prev_av[23:21] != 3'd0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL seg_unexpected: actual bg=%0d len=%0d required=none",
                   prev_av[23:21], run_len);
        end else begin
          e = exp_q.pop_front();
          check("seg_bg", 32'(prev_av[23:21]), 32'(e.bg));
          check("seg_audio_res", 32'(prev_av[20]), 32'(e.ar));
          check("seg_half_wav", 32'(prev_av[19:0]), 32'(e.hw));
          check("seg_len", run_len, e.len);
        end
      end
      prev_av = cur;
      run_len = 1;
    end
  end

  initial begin
    reset         = 1'b1;
    keycode       = 8'h00;
    keycode_ready = 1'b0;
    make          = 1'b0;
    m_lfsr        = 8'hB5;
    m_best        = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("reset");
    mon_on = 1'b1;

    play_game(4);
    play_game(1);
    play_game(0);
    play_game(2 + int'($urandom_range(4)));
    drain();

    // Reset in the middle of the first playback step
    mon_on = 1'b0;
    drive_cycle(8'h5A, 1'b1, 1'b1);
    m_seq.delete();
    m_seq.push_back(int'(m_lfsr[1:0]));
    noise_cycles(5, NZ_BUSY);
    check("show_bg", 32'(bg), m_seq[0] + 1);
    check("show_half_wav", 32'(half_wav), tone_tab[m_seq[0]]);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    m_lfsr = 8'hB5;
    m_best = 0;
    check_idle("mid_reset");
    mon_on = 1'b1;

    play_game(2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
